spi_dac8512_rx: RTL and testbench

//  DAC8512-side receiver: deserialises the 3-wire frame (NCS, SCLK, SDAT) plus NLD/NCLR strobes

---
 rtl/spi_dac8512_pkg.sv | 19 +
 rtl/spi_dac8512_rx_sync_edge.sv | 33 +++
 rtl/spi_dac8512_rx.sv | 130 +++++++++++++
 tb/tb_spi_dac8512_rx.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_dac8512_pkg.sv
// Shared types and sizing for the DAC8512 receiver model.
package spi_dac8512_pkg;

    localparam int DW_DEF   = 12;
    localparam int SYNC_DEF = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_e;

    // Bit counter must hold 0..DW+1 so an over-long frame stays distinguishable from DW.
    function automatic int bcnt_width(input int dw);
        return $clog2(dw + 2);
    endfunction

    localparam int BCNT_W_DEF = bcnt_width(DW_DEF);

endpackage

// File: rtl/spi_dac8512_rx_sync_edge.sv
// Multi-flop synchroniser with rise/fall pulses taken from the last stage.
module sync_edge
    import spi_dac8512_pkg::*;
#(
    parameter int   STAGES  = SYNC_DEF,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            last_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            last_q <= sync_q[STAGES-1];
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o = sync_q[STAGES-1] & ~last_q;
    assign fall_o = ~sync_q[STAGES-1] & last_q;

endmodule

// File: rtl/spi_dac8512_rx.sv
// DAC8512 stand-in: deserialises NCS/SCLK/SDAT frames into an input register and a DAC register.
// Optional strict frame-length checking when SPI_RX_FRAME_CHK_EN is defined.
module spi_dac8512_rx
    import spi_dac8512_pkg::*;
#(
    parameter int DW          = DW_DEF,
    parameter int SYNC_STAGES = SYNC_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ncs,
    input  logic          sclk,
    input  logic          sdat,
    input  logic          nld,
    input  logic          nclr,
    output logic [DW-1:0] din_reg,
    output logic          word_vld,
    output logic [DW-1:0] dout,
    output logic          dac_upd,
    output logic          frame_err
);

    localparam int             NS       = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int             BCW      = bcnt_width(DW);
    localparam logic [BCW-1:0] BCNT_MAX = BCW'(DW + 1);

    logic ncs_s, ncs_rise, ncs_fall;
    logic sclk_s, sclk_rise, sclk_fall_unused;
    logic sdat_s, sdat_rise_unused, sdat_fall_unused;
    logic nld_s, nld_rise_unused, nld_fall_unused;
    logic nclr_s, nclr_rise_unused, nclr_fall_unused;

    sync_edge #(.STAGES(NS), .RST_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .d_i(ncs),
        .q_o(ncs_s), .rise_o(ncs_rise), .fall_o(ncs_fall));
    sync_edge #(.STAGES(NS), .RST_VAL(1'b1)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d_i(sclk),
        .q_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall_unused));
    sync_edge #(.STAGES(NS), .RST_VAL(1'b0)) u_sync_sdat (
        .clk(clk), .rst_n(rst_n), .d_i(sdat),
        .q_o(sdat_s), .rise_o(sdat_rise_unused), .fall_o(sdat_fall_unused));
    sync_edge #(.STAGES(NS), .RST_VAL(1'b1)) u_sync_nld (
        .clk(clk), .rst_n(rst_n), .d_i(nld),
        .q_o(nld_s), .rise_o(nld_rise_unused), .fall_o(nld_fall_unused));
    sync_edge #(.STAGES(NS), .RST_VAL(1'b1)) u_sync_nclr (
        .clk(clk), .rst_n(rst_n), .d_i(nclr),
        .q_o(nclr_s), .rise_o(nclr_rise_unused), .fall_o(nclr_fall_unused));

    rx_state_e      state_q;
    logic [DW-1:0]  shift_q;
    logic [BCW-1:0] bit_cnt_q;
    logic [DW-1:0]  din_q;
    logic [DW-1:0]  din_d;
    logic [DW-1:0]  dout_q;
    logic           word_vld_q;
    logic           dac_upd_q;
    logic           frame_end;
    logic           accept;

    // din_d is the value din_reg will hold next cycle, so a coincident load sees the new word.
    always_comb begin
        frame_end = (state_q == SHIFT) && ncs_rise;
`ifdef SPI_RX_FRAME_CHK_EN
        accept    = frame_end && (bit_cnt_q == BCW'(DW));
`else
        accept    = frame_end && (bit_cnt_q != '0);
`endif
        din_d     = accept ? shift_q : din_q;
    end

`ifdef SPI_RX_FRAME_CHK_EN
    logic frame_err_q;
    assign frame_err = frame_err_q;
`else
    assign frame_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            din_q       <= '0;
            dout_q      <= '0;
            word_vld_q  <= 1'b0;
            dac_upd_q   <= 1'b0;
`ifdef SPI_RX_FRAME_CHK_EN
            frame_err_q <= 1'b0;
`endif
        end else begin
            word_vld_q  <= 1'b0;
            dac_upd_q   <= 1'b0;
`ifdef SPI_RX_FRAME_CHK_EN
            frame_err_q <= frame_end && !accept;
`endif
            case (state_q)
                IDLE: begin
                    if (ncs_fall) begin
                        state_q   <= SHIFT;
                        shift_q   <= '0;
                        bit_cnt_q <= '0;
                    end
                end
                SHIFT: begin
                    if (ncs_rise) begin
                        state_q    <= IDLE;
                        din_q      <= din_d;
                        word_vld_q <= accept;
                    end else if (sclk_rise) begin
                        shift_q <= {shift_q[DW-2:0], sdat_s};
                        if (bit_cnt_q != BCNT_MAX) bit_cnt_q <= bit_cnt_q + BCW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (!nclr_s) begin
                dout_q <= '0;
            end else if (!nld_s) begin
                dout_q    <= din_d;
                dac_upd_q <= 1'b1;
            end
        end
    end

    assign din_reg  = din_q;
    assign word_vld = word_vld_q;
    assign dout     = dout_q;
    assign dac_upd  = dac_upd_q;

endmodule

// File: tb/tb_spi_dac8512_rx.sv
// Self-checking bench for spi_dac8512_rx with a frame-level reference model.
module tb_spi_dac8512_rx;

    localparam int DW = 12;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          ncs   = 1'b1;
    logic          sclk  = 1'b1;
    logic          sdat  = 1'b0;
    logic          nld   = 1'b1;
    logic          nclr  = 1'b1;
    logic [DW-1:0] din_reg;
    logic          word_vld;
    logic [DW-1:0] dout;
    logic          dac_upd;
    logic          frame_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] exp_din  = '0;
    logic [DW-1:0] exp_dout = '0;

    always #5 clk = ~clk;

    spi_dac8512_rx #(.DW(DW), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .ncs(ncs), .sclk(sclk), .sdat(sdat),
        .nld(nld), .nclr(nclr), .din_reg(din_reg), .word_vld(word_vld),
        .dout(dout), .dac_upd(dac_upd), .frame_err(frame_err));

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic bit chk_en();
`ifdef SPI_RX_FRAME_CHK_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // The register keeps the last min(n,DW) bits shifted in, starting from zero.
    function automatic logic [DW-1:0] frame_word(input int val, input int n);
        int k;
        k = (n < DW) ? n : DW;
        return DW'(val & ((1 << k) - 1));
    endfunction

    function automatic bit frame_ok(input int n);
        return chk_en() ? (n == DW) : (n >= 1);
    endfunction

    task automatic send_bits(input int val, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            sclk = 1'b0;
            sdat = val[i];
            tick($urandom_range(1, 2));
            sclk = 1'b1;
            tick($urandom_range(1, 2));
        end
    endtask

    task automatic close_frame(input string name, input int val, input int n, input bit with_nld);
        logic [DW-1:0] w;
        bit            ok;
        w  = frame_word(val, n);
        ok = frame_ok(n);
        ncs = 1'b1;
        if (with_nld) nld = 1'b0;
        tick();
        nld = 1'b1;
        tick();
        n_tests++;
        if (word_vld !== 1'b0 || dac_upd !== 1'b0 || din_reg !== exp_din) begin
            n_fail++;
            $display("FAIL %s early: word_vld=%b dac_upd=%b din_reg=%h, required 0 0 %h",
                     name, word_vld, dac_upd, din_reg, exp_din);
        end
        if (ok) exp_din = w;
        if (with_nld) exp_dout = exp_din;
        tick();
        n_tests++;
        if (word_vld !== ok || dac_upd !== with_nld || frame_err !== (chk_en() && !ok) ||
            din_reg !== exp_din || dout !== exp_dout) begin
            n_fail++;
            $display("FAIL %s pulse: vld=%b upd=%b err=%b din=%h dout=%h, required %b %b %b %h %h",
                     name, word_vld, dac_upd, frame_err, din_reg, dout,
                     ok, with_nld, chk_en() && !ok, exp_din, exp_dout);
        end
        tick();
        n_tests++;
        if (word_vld !== 1'b0 || dac_upd !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s after: vld=%b upd=%b err=%b, required 0 0 0",
                     name, word_vld, dac_upd, frame_err);
        end
    endtask

    task automatic frame(input string name, input int val, input int n, input bit with_nld);
        ncs = 1'b0;
        tick($urandom_range(1, 2));
        send_bits(val, n);
        close_frame(name, val, n, with_nld);
    endtask

    task automatic check_idle_outputs(input string name);
        n_tests++;
        if (din_reg !== exp_din || dout !== exp_dout || word_vld !== 1'b0 ||
            dac_upd !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: din=%h dout=%h vld=%b upd=%b err=%b, required %h %h 0 0 0",
                     name, din_reg, dout, word_vld, dac_upd, frame_err, exp_din, exp_dout);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        exp_din  = '0;
        exp_dout = '0;
        check_idle_outputs("reset_held");
        rst_n = 1'b1;
        tick(4);
        check_idle_outputs("reset_released");
    endtask

    task automatic test_load_frame();
        frame("load_a5c", 'hA5C, 12, 1'b1);
    endtask

    task automatic test_clear();
        nclr = 1'b0;
        tick(3);
        exp_dout = '0;
        n_tests++;
        if (dout !== exp_dout || din_reg !== exp_din || dac_upd !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_low: dout=%h din=%h upd=%b, required %h %h 0",
                     dout, din_reg, dac_upd, exp_dout, exp_din);
        end
        nclr = 1'b1;
        tick(4);
        check_idle_outputs("clear_released");
        nld = 1'b0;
        tick();
        nld = 1'b1;
        tick(2);
        exp_dout = exp_din;
        n_tests++;
        if (dout !== exp_dout || dac_upd !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_reload: dout=%h upd=%b, required %h 1", dout, dac_upd, exp_dout);
        end
        tick();
        check_idle_outputs("clear_reload_end");
    endtask

    task automatic test_short_frame();
        frame("short8", 'h3C, 8, 1'b0);
    endtask

    task automatic test_long_frame();
        frame("long14", 'h2ABC, 14, 1'b0);
    endtask

    task automatic test_reset_midframe();
        ncs = 1'b0;
        tick(2);
        send_bits('h1B, 5);
        rst_n = 1'b0;
        #1;
        exp_din  = '0;
        exp_dout = '0;
        check_idle_outputs("rst_midframe");
        tick(2);
        rst_n = 1'b1;
        tick(4);
        send_bits('h5, 3);
        close_frame("rst_partial", 'h5, 3, 1'b0);
        frame("after_rst", 'h123, 12, 1'b1);
    endtask

    task automatic test_nld_nclr();
        nld  = 1'b0;
        nclr = 1'b0;
        tick(3);
        exp_dout = '0;
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (dout !== exp_dout || dac_upd !== 1'b0) begin
                n_fail++;
                $display("FAIL nld_nclr_both: dout=%h upd=%b, required %h 0", dout, dac_upd, exp_dout);
            end
            tick();
        end
        nclr = 1'b1;
        tick(3);
        exp_dout = exp_din;
        n_tests++;
        if (dout !== exp_dout || dac_upd !== 1'b1) begin
            n_fail++;
            $display("FAIL nclr_release: dout=%h upd=%b, required %h 1", dout, dac_upd, exp_dout);
        end
        nld = 1'b1;
        tick(3);
        check_idle_outputs("nld_release");
    endtask

    task automatic test_random();
        int  val;
        int  n;
        bit  wn;
        for (int it = 0; it < 25; it++) begin
            val = int'($urandom);
            n   = int'($urandom_range(1, 15));
            wn  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                for (int j = 0; j < 3; j++) begin
                    sclk = 1'b0;
                    sdat = 1'($urandom_range(0, 1));
                    tick();
                    sclk = 1'b1;
                    tick();
                end
                tick(3);
                check_idle_outputs("idle_sclk");
            end
            frame("random", val, n, wn);
        end
    endtask

    initial begin
        test_reset();
        test_load_frame();
        test_clear();
        test_short_frame();
        test_long_frame();
        test_reset_midframe();
        test_nld_nclr();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
